muldiv_unit: RTL
================

// Module: muldiv_unit
// PURPOSE
//  Iterative multiply/divide unit in EX; consumes ID/EX register outputs (d1_out/d2_out/aluctrl_out).
//  Executes MULT/MULTU/DIV/DIVU over multiple cycles into architectural HI/LO; handles MTHI/MTLO.
//  Drives busy back to the hazard logic, which stalls IF/ID/EX while busy=1.
// PARAMETERS
//  WIDTH  32  operand/HI/LO width; iteration count = WIDTH
// PORTS
//  clock   in   1      single clock, rising edge
//  reset   in   1      asynchronous, active-low; clears all state
//  start   in   1      op valid this cycle (decoded from aluctrl_out)
//  op      in   3      000 NONE,001 MULT,010 MULTU,011 DIV,100 DIVU,101 MTHI,110 MTLO
//  kill    in   1      synchronous abort (EX flush)
//  rs_val  in   WIDTH  operand A / dividend / MTHI-MTLO source (d1_out)
//  rt_val  in   WIDTH  operand B / divisor (d2_out)
//  hi      out  WIDTH  HI register
//  lo      out  WIDTH  LO register
//  busy    out  1      1 while state != IDLE; registered-state derived, no input path
//  done    out  1      one-cycle pulse in the cycle hi/lo become the new result
// BEHAVIOUR
//  Reset (reset=0, async): state=IDLE, hi=0, lo=0, busy=0, done=0, counter=0, work regs=0.
//  States: IDLE -> RUN -> FIXUP -> IDLE.
//  IDLE: start=1 & op in {MULT..DIVU}: latch |rs_val|,|rt_val| (MULT/DIV take magnitudes; U ops raw),
//   record result signs, counter=WIDTH-1, -> RUN. busy=1 from the next cycle.
//  IDLE: start=1 & op=MTHI: hi<=rs_val next edge; MTLO: lo<=rs_val; single cycle, busy stays 0, no done.
//  IDLE: op=NONE or start=0: hold. Illegal op codes 111: treated as NONE.
//  RUN: one shift-add (mul) or restoring subtract (div) step per cycle, WIDTH cycles total;
//   counter==0 in RUN -> FIXUP.
//  FIXUP: apply sign: MULT product negated if signs differ (2*WIDTH-bit two's complement);
//   DIV quotient negated if signs differ, remainder takes dividend sign. Write hi/lo, done=1, -> IDLE.
//  Latency: start sampled at edge 0 -> hi/lo updated and done=1 after edge WIDTH+1 (34 cycles @32);
//   next start accepted in the cycle done=1 is high.
//  MUL results: hi=product[2W-1:W], lo=product[W-1:0].
//  DIV results: lo=quotient, hi=remainder.
//  Divide by zero (DIV/DIVU): lo=all ones, hi=rs_val as latched (raw, unsigned magnitude path, no sign fix).
//  DIV -2^(W-1) / -1: lo=0x80000000, hi=0 (magnitude math, no trap).
//  start while busy=1: ignored (hazard logic must stall); hi/lo/state unaffected.
//  kill=1 in any state: -> IDLE next edge, hi/lo unchanged, done=0; kill & start same cycle: kill wins.
//  reset deasserted mid-operation: operation lost, restart from IDLE with hi=lo=0.
//  hi/lo only ever change on reset, MTHI/MTLO in IDLE, or FIXUP completion.
// STRUCTURE
//  Shared package mips_pkg: op encodings (MD_NONE..MD_MTLO), state enum (IDLE/RUN/FIXUP),
//   ALU NOOP code 5'b01101 shared with decode.
//  One sub-module: muldiv_step -- combinational single-iteration datapath
//   (shift-add and restoring-subtract), selected by is_div; FSM/counter/sign-fix stay in top.
//  Counter width $clog2(WIDTH); work register 2*WIDTH+1 bits.
// TESTING
//  MULTU 0xFFFFFFFF*0xFFFFFFFF -> after 34 cycles hi=0xFFFFFFFE, lo=0x00000001, done 1 cycle.
//  MULT -3*5 -> hi=0xFFFFFFFF, lo=0xFFFFFFF1; busy high exactly 33 cycles post-start edge.
//  DIV -7/2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF; DIVU 7/0 -> lo=0xFFFFFFFF, hi=0x00000007.
//  DIV 0x80000000/0xFFFFFFFF -> lo=0x80000000, hi=0; MTHI 0x1234 in IDLE -> hi=0x1234 next edge, no done.
//  Start DIVU, kill at cycle 10 -> busy=0 next edge, hi/lo keep prior values, no done; start during busy ignored.
//  Assert reset low at cycle 5 of MULT -> immediately hi=lo=0, busy=0; new MULT after release completes correctly.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared encodings for the EX-stage multiply/divide unit and the decode stage.
package mips_pkg;

  localparam logic [4:0] ALU_NOOP = 5'b01101;

  typedef enum logic [2:0] {
    MD_NONE  = 3'b000,
    MD_MULT  = 3'b001,
    MD_MULTU = 3'b010,
    MD_DIV   = 3'b011,
    MD_DIVU  = 3'b100,
    MD_MTHI  = 3'b101,
    MD_MTLO  = 3'b110
  } md_op_e;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FIXUP = 2'd2
  } md_state_e;

endpackage

// File: rtl/muldiv_step.sv
// One iteration of the unsigned datapath: right-shifting shift-add multiply or
// left-shifting restoring divide over a shared 2*WIDTH+1 bit work register.
module muldiv_step #(
  parameter int unsigned WIDTH = 32
) (
  input  logic               is_div,
  input  logic [2*WIDTH:0]   work_in,
  input  logic [WIDTH-1:0]   operand_b,
  output logic [2*WIDTH:0]   work_out
);

  logic [WIDTH:0]   mul_sum;
  logic [WIDTH+1:0] trial;
  logic [WIDTH+1:0] diff;
  logic             ge;
  logic [WIDTH:0]   new_rem;

  // Multiply: {acc, multiplier}; divide: {remainder, dividend/quotient}
  always_comb begin
    mul_sum  = work_in[2*WIDTH:WIDTH] + (work_in[0] ? {1'b0, operand_b} : '0);
    trial    = work_in[2*WIDTH:WIDTH-1];
    diff     = trial - {2'b00, operand_b};
    ge       = ~diff[WIDTH+1];
    new_rem  = ge ? diff[WIDTH:0] : trial[WIDTH:0];
    work_out = is_div ? {new_rem, work_in[WIDTH-2:0], ge}
                      : {1'b0, mul_sum, work_in[WIDTH-1:1]};
  end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit with architectural HI/LO and MTHI/MTLO;
// busy stalls the front of the pipe while an operation is in flight.
module muldiv_unit
  import mips_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic             kill,
  input  logic [WIDTH-1:0] rs_val,
  input  logic [WIDTH-1:0] rt_val,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             done
);

  localparam int unsigned CNT_W  = $clog2(WIDTH);
  localparam int unsigned WORK_W = 2 * WIDTH + 1;

  md_state_e          state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WORK_W-1:0]  work_q, work_d, step_out;
  logic [WIDTH-1:0]   divisor_q, divisor_d;
  logic               is_div_q, is_div_d;
  logic               neg_q_q, neg_q_d;
  logic               neg_r_q, neg_r_d;
  logic               div_zero_q, div_zero_d;
  logic [WIDTH-1:0]   hi_d, lo_d;
  logic               busy_d, done_d;

  logic               is_signed;
  logic               a_neg, b_neg;
  logic [WIDTH-1:0]   a_mag, b_mag;
  logic [2*WIDTH-1:0] product, product_neg;
  logic [WIDTH-1:0]   quot, rem;

  muldiv_step #(.WIDTH(WIDTH)) u_step (
    .is_div    (is_div_q),
    .work_in   (work_q),
    .operand_b (divisor_q),
    .work_out  (step_out)
  );

  // Operand magnitudes and sign capture for the signed ops
  assign is_signed   = (op == MD_MULT) || (op == MD_DIV);
  assign a_neg       = is_signed & rs_val[WIDTH-1];
  assign b_neg       = is_signed & rt_val[WIDTH-1];
  assign a_mag       = a_neg ? (~rs_val + WIDTH'(1)) : rs_val;
  assign b_mag       = b_neg ? (~rt_val + WIDTH'(1)) : rt_val;

  assign product     = work_q[2*WIDTH-1:0];
  assign product_neg = ~product + (2*WIDTH)'(1);
  assign quot        = work_q[WIDTH-1:0];
  assign rem         = work_q[2*WIDTH-1:WIDTH];

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    work_d     = work_q;
    divisor_d  = divisor_q;
    is_div_d   = is_div_q;
    neg_q_d    = neg_q_q;
    neg_r_d    = neg_r_q;
    div_zero_d = div_zero_q;
    hi_d       = hi;
    lo_d       = lo;
    done_d     = 1'b0;

    if (kill) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            case (op)
              MD_MULT, MD_MULTU, MD_DIV, MD_DIVU: begin
                state_d    = RUN;
                cnt_d      = CNT_W'(WIDTH - 1);
                work_d     = {{(WIDTH + 1){1'b0}}, a_mag};
                divisor_d  = b_mag;
                is_div_d   = (op == MD_DIV) || (op == MD_DIVU);
                neg_q_d    = a_neg ^ b_neg;
                neg_r_d    = a_neg;
                div_zero_d = (rt_val == '0);
              end
              MD_MTHI: hi_d = rs_val;
              MD_MTLO: lo_d = rs_val;
              default: ;
            endcase
          end
        end
        RUN: begin
          work_d = step_out;
          if (cnt_q == '0) state_d = FIXUP;
          else             cnt_d   = cnt_q - CNT_W'(1);
        end
        FIXUP: begin
          // Divide-by-zero keeps the raw unsigned result: all-ones / dividend
          if (!is_div_q) begin
            hi_d = neg_q_q ? product_neg[2*WIDTH-1:WIDTH] : product[2*WIDTH-1:WIDTH];
            lo_d = neg_q_q ? product_neg[WIDTH-1:0]       : product[WIDTH-1:0];
          end else if (div_zero_q) begin
            hi_d = rem;
            lo_d = quot;
          end else begin
            hi_d = neg_r_q ? (~rem  + WIDTH'(1)) : rem;
            lo_d = neg_q_q ? (~quot + WIDTH'(1)) : quot;
          end
          done_d  = 1'b1;
          state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      work_q     <= '0;
      divisor_q  <= '0;
      is_div_q   <= 1'b0;
      neg_q_q    <= 1'b0;
      neg_r_q    <= 1'b0;
      div_zero_q <= 1'b0;
      hi         <= '0;
      lo         <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      work_q     <= work_d;
      divisor_q  <= divisor_d;
      is_div_q   <= is_div_d;
      neg_q_q    <= neg_q_d;
      neg_r_q    <= neg_r_d;
      div_zero_q <= div_zero_d;
      hi         <= hi_d;
      lo         <= lo_d;
      busy       <= busy_d;
      done       <= done_d;
    end
  end

endmodule
